// File: rtl/key_pulse_bank.sv
// N-channel key front end: 2-flop sync, debounce, one-cycle press pulse per channel.
// Define KEY_REPEAT_EN to compile in auto-repeat pulses while a key stays held.
module key_pulse_bank #(
  parameter int N            = 4,
  parameter int DEBOUNCE     = 4,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] keypress,
  output logic [N-1:0] userin,
  output logic [N-1:0] held,
  output logic         any_press
);

  // state | meaning
  // IDLE  | debounced level low
  // PRESS | the single cycle userin is high for a new press
  // HOLD  | debounced level high, no pulse
  // REPEAT| auto-repeating while held (KEY_REPEAT_EN only)
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_HOLD  = 2'd2
`ifdef KEY_REPEAT_EN
    , ST_REPEAT = 2'd3
`endif
  } state_e;

  localparam int DBW = $clog2(DEBOUNCE + 1);

  if (N < 1 || N > 32 || DEBOUNCE < 1 || DEBOUNCE > 65535 ||
      REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_bad_cfg
    $error("key_pulse_bank: parameter out of range");
  end

  logic [N-1:0]   sync1_q, sync2_q;
  logic [N-1:0]   held_q, held_d;
  logic [N-1:0]   rise, fall;
  logic [N-1:0]   userin_q, userin_d;
  logic           any_press_q;
  logic [DBW-1:0] db_cnt_q [N];
  logic [DBW-1:0] db_cnt_d [N];
  state_e         state_q [N];
  state_e         state_d [N];

`ifdef KEY_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  logic [RW-1:0] rpt_cnt_q [N];
  logic [RW-1:0] rpt_cnt_d [N];
  logic [N-1:0]  rpt_tc;
`endif

  // Debounce: count consecutive cycles where sync2 disagrees with held.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      held_d[i]   = held_q[i];
      db_cnt_d[i] = '0;
      rise[i]     = 1'b0;
      fall[i]     = 1'b0;
      if (sync2_q[i] != held_q[i]) begin
        if (db_cnt_q[i] == DBW'(DEBOUNCE - 1)) begin
          held_d[i] = sync2_q[i];
          rise[i]   = sync2_q[i];
          fall[i]   = ~sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      held_q      <= '0;
      userin_q    <= '0;
      any_press_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        db_cnt_q[i] <= '0;
        state_q[i]  <= ST_IDLE;
`ifdef KEY_REPEAT_EN
        rpt_cnt_q[i] <= '0;
`endif
      end
    end else begin
      sync1_q     <= keypress;
      sync2_q     <= sync1_q;
      held_q      <= held_d;
      userin_q    <= userin_d;
      any_press_q <= |userin_d;
      for (int i = 0; i < N; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
        state_q[i]  <= state_d[i];
`ifdef KEY_REPEAT_EN
        rpt_cnt_q[i] <= rpt_cnt_d[i];
`endif
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
`ifdef KEY_REPEAT_EN
      rpt_tc[i] = (rpt_cnt_q[i] == '0);
`endif
      case (state_q[i])
        ST_IDLE:  if (rise[i]) state_d[i] = ST_PRESS;
        ST_PRESS: state_d[i] = fall[i] ? ST_IDLE : ST_HOLD;
        ST_HOLD: begin
          if (fall[i]) state_d[i] = ST_IDLE;
`ifdef KEY_REPEAT_EN
          else if (rpt_tc[i]) state_d[i] = ST_REPEAT;
`endif
        end
`ifdef KEY_REPEAT_EN
        ST_REPEAT: if (fall[i]) state_d[i] = ST_IDLE;
`endif
        default:  state_d[i] = ST_IDLE;
      endcase
    end
  end

  // Pulses are registered so userin and any_press leave the flops together.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      userin_d[i] = (state_d[i] == ST_PRESS);
`ifdef KEY_REPEAT_EN
      rpt_cnt_d[i] = '0;
      if (state_d[i] == ST_PRESS) begin
        rpt_cnt_d[i] = RW'(REPEAT_DELAY - 1);
      end else if (state_d[i] != ST_IDLE) begin
        if (rpt_tc[i]) begin
          userin_d[i]  = 1'b1;
          rpt_cnt_d[i] = RW'(REPEAT_RATE - 1);
        end else begin
          rpt_cnt_d[i] = rpt_cnt_q[i] - RW'(1);
        end
      end
`endif
    end
  end

  assign userin    = userin_q;
  assign held      = held_q;
  assign any_press = any_press_q;

endmodule
